// File: rtl/addr_result_queue.sv
// addr_result_queue: small circular FIFO that buffers issue-stage adder
// results until the common data bus arbiter grants the head entry.
// Optional feature: define ADDR_RESULT_QUEUE_STALL_CNT_EN to build a 32-bit
// counter of cycles in which the head entry requested the CDB but was refused.
// Without the macro, stall_count is tied to zero and no counter is built.
module addr_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int ROB_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_result,
  input  logic [TAG_W-1:0]         in_dest_tag,
  input  logic [ROB_W-1:0]         in_rob_idx,
  output logic                     in_ready,
  input  logic                     squash,
  input  logic                     cdb_grant,
  output logic                     cdb_req,
  output logic [31:0]              cdb_result,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [ROB_W-1:0]         cdb_rob_idx,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              stall_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + TAG_W + ROB_W;

  // Entry storage; contents are meaningless unless covered by r_count,
  // so it carries no reset.
  logic [ENT_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_enq;
  logic             w_deq;
  logic [ENT_W-1:0] w_head_ent;

  // Ready comes only from the count register, so a grant can never ripple
  // combinationally back into the issue stage.
  assign in_ready = (r_count < CNT_W'(DEPTH));
  assign cdb_req  = (r_count != '0);
  assign occupancy = r_count;

  assign w_enq = in_valid && in_ready;
  assign w_deq = cdb_req && cdb_grant;

  assign w_head_ent = r_mem[r_head];

  // Pointer and count update; squash empties the queue and wins over any
  // same-cycle enqueue or dequeue. DEPTH is a power of two, so the pointers
  // wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write the accepted entry at the tail slot.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem[r_tail] <= {in_result, in_dest_tag, in_rob_idx};
    end
  end

  // Head fields are presented only while an entry is valid; zero otherwise.
  always_comb begin
    cdb_result  = '0;
    cdb_tag     = '0;
    cdb_rob_idx = '0;
    if (cdb_req) begin
      cdb_result  = w_head_ent[ENT_W-1 -: 32];
      cdb_tag     = w_head_ent[ROB_W +: TAG_W];
      cdb_rob_idx = w_head_ent[ROB_W-1:0];
    end
  end

`ifdef ADDR_RESULT_QUEUE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count cycles where the head entry waits on the arbiter; squash leaves it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (cdb_req && !cdb_grant) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = '0;
`endif

endmodule
